// File: rtl/hazard_ctrl.sv
// hazard_ctrl: ID-stage issue/stall/forward decision from the register-invalid scoreboard
// Ports: clk, reset (async, active-low), register_invalid[8] 3-bit pending-write counters,
//   id_valid, rs/rt address and use flags, flush -> stall_id, issue_ok, fwd_rs, fwd_rt,
//   hazard_err (sticky watchdog), stall_cnt (saturating stall-cycle counter).
// Option: HAZARD_FWD_EN lets a counter of exactly 1 be taken from the writeback bypass latch.
module hazard_ctrl #(
  parameter int MAX_STALL = 15,
  parameter int PERF_W    = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [7:0][2:0]      register_invalid,
  input  logic                 id_valid,
  input  logic [2:0]           rs_adr_id,
  input  logic                 rs_use_id,
  input  logic [2:0]           rt_adr_id,
  input  logic                 rt_use_id,
  input  logic                 flush,
  output logic                 stall_id,
  output logic                 issue_ok,
  output logic                 fwd_rs,
  output logic                 fwd_rt,
  output logic                 hazard_err,
  output logic [PERF_W-1:0]    stall_cnt
);
  localparam int WW = $clog2(MAX_STALL + 1);
  typedef enum logic [1:0] {RUN, STALL, ERR} state_t;
  state_t state, state_nx;
  logic [WW-1:0] wait_cnt, wait_nx;
  logic [2:0] rs_cnt, rt_cnt;
  logic rs_pend, rt_pend, rs_rdy, rt_rdy, hazard;
  assign rs_cnt = register_invalid[rs_adr_id];
  assign rt_cnt = register_invalid[rt_adr_id];
`ifdef HAZARD_FWD_EN
  assign rs_pend = rs_use_id && rs_cnt >= 3'd2;
  assign rt_pend = rt_use_id && rt_cnt >= 3'd2;
  assign rs_rdy  = rs_use_id && rs_cnt == 3'd1;
  assign rt_rdy  = rt_use_id && rt_cnt == 3'd1;
`else
  assign rs_pend = rs_use_id && rs_cnt != 3'd0;
  assign rt_pend = rt_use_id && rt_cnt != 3'd0;
  assign rs_rdy  = 1'b0;
  assign rt_rdy  = 1'b0;
`endif
  assign hazard = id_valid && (rs_pend || rt_pend);
  assign hazard_err = state == ERR;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= RUN;
      wait_cnt  <= '0;
      stall_cnt <= '0;
    end else begin
      state    <= state_nx;
      wait_cnt <= wait_nx;
      if (stall_id && !(&stall_cnt)) stall_cnt <= stall_cnt + 1'b1;
    end
  end
  // wait_cnt counts stalled cycles of the current instruction; ERR is entered
  // once that count reaches MAX_STALL with the hazard still present.
  always_comb begin
    state_nx = state;
    wait_nx  = wait_cnt;
    if (state != ERR) begin
      if (flush || !hazard) begin
        state_nx = RUN;
        wait_nx  = '0;
      end else if (state == RUN) begin
        state_nx = (MAX_STALL <= 1) ? ERR : STALL;
        wait_nx  = WW'(1);
      end else begin
        wait_nx  = wait_cnt + 1'b1;
        state_nx = (wait_nx == WW'(MAX_STALL)) ? ERR : STALL;
      end
    end
  end
  always_comb begin
    stall_id = 1'b0;
    issue_ok = 1'b0;
    fwd_rs   = 1'b0;
    fwd_rt   = 1'b0;
    if (reset) begin
      if (state == ERR) stall_id = 1'b1;
      else if (!flush) begin
        stall_id = hazard;
        issue_ok = id_valid && !hazard;
        fwd_rs   = id_valid && rs_rdy;
        fwd_rt   = id_valid && rt_rdy;
      end
    end
  end
endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: randomized and directed check of hazard_ctrl against a behavioural model
module tb_hazard_ctrl;
  localparam int MAX = 15;
  localparam int PW  = 8;
`ifdef HAZARD_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif
  logic clk = 1'b0, reset = 1'b0;
  logic [7:0][2:0] ri = '0;
  logic id_valid = 1'b0, rs_use = 1'b0, rt_use = 1'b0, flush = 1'b0;
  logic [2:0] rs = '0, rt = '0;
  logic stall_id, issue_ok, fwd_rs, fwd_rt, hazard_err;
  logic [PW-1:0] stall_cnt;
  int n_vec = 0, n_err = 0;
  int m_run = 0, m_perf = 0;
  bit m_err = 1'b0;
  hazard_ctrl #(.MAX_STALL(MAX), .PERF_W(PW)) dut (
    .clk(clk), .reset(reset), .register_invalid(ri), .id_valid(id_valid),
    .rs_adr_id(rs), .rs_use_id(rs_use), .rt_adr_id(rt), .rt_use_id(rt_use),
    .flush(flush), .stall_id(stall_id), .issue_ok(issue_ok), .fwd_rs(fwd_rs),
    .fwd_rt(fwd_rt), .hazard_err(hazard_err), .stall_cnt(stall_cnt)
  );
  always #5 clk = ~clk;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask
  function automatic bit pend(input bit u, input logic [2:0] v);
    return FWD ? (u && v >= 3'd2) : (u && v != 3'd0);
  endfunction
  // Model: a stall is "hazard unless flushed", ERR after MAX consecutive stalled cycles.
  always @(negedge clk) begin : cmp
    bit hz, es, ei, efs, eft;
    if (!reset) begin
      m_err = 1'b0; m_run = 0; m_perf = 0;
      hz = 0; es = 0; ei = 0; efs = 0; eft = 0;
    end else begin
      hz  = id_valid && (pend(rs_use, ri[rs]) || pend(rt_use, ri[rt]));
      es  = m_err ? 1'b1 : (flush ? 1'b0 : hz);
      ei  = !m_err && !flush && id_valid && !hz;
      efs = FWD && !m_err && !flush && id_valid && rs_use && ri[rs] == 3'd1;
      eft = FWD && !m_err && !flush && id_valid && rt_use && ri[rt] == 3'd1;
    end
    chk("stall_id", 32'(stall_id), 32'(es));
    chk("issue_ok", 32'(issue_ok), 32'(ei));
    chk("fwd_rs", 32'(fwd_rs), 32'(efs));
    chk("fwd_rt", 32'(fwd_rt), 32'(eft));
    chk("hazard_err", 32'(hazard_err), 32'(m_err));
    chk("stall_cnt", 32'(stall_cnt), 32'(m_perf));
    if (reset) begin
      if (es && m_perf < (1 << PW) - 1) m_perf++;
      if (!m_err) begin
        if (flush || !hz) m_run = 0;
        else begin
          m_run++;
          if (m_run == MAX) m_err = 1'b1;
        end
      end
    end
  end
  task automatic nx();
    @(posedge clk);
    #1;
  endtask
  task automatic smp();
    @(negedge clk);
    #1;
  endtask
  task automatic rst();
    nx();
    reset = 1'b0; ri = '0; id_valid = 0; rs_use = 0; rt_use = 0; flush = 0; rs = 0; rt = 0;
    smp();
    chk("rst_stall_cnt", 32'(stall_cnt), 0);
    chk("rst_hazard_err", 32'(hazard_err), 0);
    chk("rst_stall_id", 32'(stall_id), 0);
    nx();
    reset = 1'b1;
  endtask
  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end
  initial begin
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    id_valid = 1; rs = 3; rs_use = 1; rt = 5; rt_use = 1;
    smp();
    chk("t1_stall", 32'(stall_id), 0);
    chk("t1_issue", 32'(issue_ok), 1);
    nx(); nx(); smp();
    chk("t1_perf", 32'(stall_cnt), 0);
    rst();
    ri[3] = 2; rs = 3; rs_use = 1; id_valid = 1;
    smp(); chk("t2_stall_a", 32'(stall_id), 1);
    nx(); ri[3] = 1;
    smp(); chk("t2_stall_b", 32'(stall_id), FWD ? 0 : 1);
    chk("t2_fwd_b", 32'(fwd_rs), FWD ? 1 : 0);
    nx(); ri[3] = 0;
    smp(); chk("t2_issue", 32'(issue_ok), 1);
    chk("t2_perf", 32'(stall_cnt), FWD ? 1 : 2);
    rst();
    ri[5] = 1; rt = 5; rt_use = 1; id_valid = 1;
    smp();
    chk("t3_stall", 32'(stall_id), FWD ? 0 : 1);
    chk("t3_issue", 32'(issue_ok), FWD ? 1 : 0);
    chk("t3_fwd_rt", 32'(fwd_rt), FWD ? 1 : 0);
    nx(); ri[5] = 0;
    smp(); chk("t3_issue2", 32'(issue_ok), 1);
    rst();
    ri[2] = 2; rs = 2; rs_use = 1; id_valid = 1;
    smp(); chk("t4_stall", 32'(stall_id), 1);
    nx(); flush = 1;
    smp(); chk("t4_flush_stall", 32'(stall_id), 0);
    chk("t4_flush_issue", 32'(issue_ok), 0);
    nx(); flush = 0; id_valid = 0;
    smp(); chk("t4_idle_stall", 32'(stall_id), 0);
    nx(); id_valid = 1;
    smp(); chk("t4_restall", 32'(stall_id), 1);
    rst();
    ri[7] = 3; rs = 7; rs_use = 1; id_valid = 1;
    repeat (14) begin smp(); nx(); end
    smp();
    chk("t5_err_pre", 32'(hazard_err), 0);
    chk("t5_perf_pre", 32'(stall_cnt), 14);
    nx(); smp();
    chk("t5_err", 32'(hazard_err), 1);
    chk("t5_perf", 32'(stall_cnt), 15);
    nx(); flush = 1;
    smp();
    chk("t5_flush_err", 32'(hazard_err), 1);
    chk("t5_flush_stall", 32'(stall_id), 1);
    nx(); flush = 0;
    repeat (250) nx();
    smp(); chk("t6_sat", 32'(stall_cnt), 255);
    repeat (5) nx();
    smp(); chk("t6_sat_hold", 32'(stall_cnt), 255);
    rst();
    repeat (4000) begin
      nx();
      reset = $urandom_range(0, 149) != 0;
      if ($urandom_range(0, 9) < 3)
        for (int r = 0; r < 8; r++)
          ri[r] = ($urandom_range(0, 9) < 6) ? 3'd0 : 3'($urandom_range(1, 7));
      id_valid = $urandom_range(0, 7) != 0;
      if ($urandom_range(0, 3) == 0) begin
        rs = 3'($urandom); rt = 3'($urandom);
        rs_use = 1'($urandom); rt_use = 1'($urandom);
      end
      flush = $urandom_range(0, 15) == 0;
    end
    nx();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
